// File: rtl/iter_sched_fix_case2_pkg.sv
// Shared definitions for the fix-case2 iteration scheduler.
// Contents: the FSM state encoding, the default J/A/ITER_W constants, and a
// small helper that flags a beat whose tlast disagrees with its position.
package iter_sched_fix_case2_pkg;

    localparam int J_DEF      = 14;  // alpha_final columns per iteration
    localparam int A_DEF      = 2;   // alpha beats per load / replay
    localparam int ITER_W_DEF = 8;   // iteration counter width

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_EXT = 3'd1,
        ST_RUN      = 3'd2,
        ST_CLEAR    = 3'd3,
        ST_REPLAY   = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // A beat is malformed when tlast is not asserted exactly on the final beat.
    function automatic logic tlast_mismatch(input logic tlast, input logic is_last);
        return tlast ^ is_last;
    endfunction

endpackage

// File: rtl/iter_sched_fix_case2.sv
// Iteration scheduler for the alpha/cal_core decode loop.
// A run loads A initial-alpha beats from the external stream, then repeats
// (J columns of col_done -> clear cores -> replay A feedback-alpha beats)
// until the latched iteration count is reached, and finishes with a done pulse.
// Ports:
//   clk, rst_n                           clock, async active-low reset
//   start, max_iter                      run request and iteration count (0 => 1)
//   abort                                synchronous abort of the current run
//   ext_alpha_tvalid/tlast, _tready      external initial-alpha beats
//   fb_alpha_tvalid/tlast                feedback-alpha beats
//   col_done                             one pulse per finished column
//   alpha_sel, core_clr, fb_launch       core alpha mux, core clear, replay launch
//   iter_cnt, busy, done, err            status (all registered)
module iter_sched_fix_case2
    import iter_sched_fix_case2_pkg::*;
#(
    parameter int J      = J_DEF,
    parameter int A      = A_DEF,
    parameter int ITER_W = ITER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iter,
    input  logic              abort,
    input  logic              ext_alpha_tvalid,
    input  logic              ext_alpha_tlast,
    output logic              ext_alpha_tready,
    input  logic              fb_alpha_tvalid,
    input  logic              fb_alpha_tlast,
    input  logic              col_done,
    output logic              alpha_sel,
    output logic              core_clr,
    output logic              fb_launch,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BEAT_W = (A > 1) ? $clog2(A) : 1;
    localparam int COL_W  = (J > 1) ? $clog2(J) : 1;

    state_t              state_r, state_s;
    logic [BEAT_W-1:0]   beat_cnt_r, beat_cnt_s;
    logic [COL_W-1:0]    col_cnt_r, col_cnt_s;
    logic [ITER_W-1:0]   iter_cnt_r, iter_cnt_s;
    logic [ITER_W-1:0]   max_r, max_s;
    logic                err_r, err_s, err_hold_s;
    logic                abort_hit_s;
    logic                beat_last_s;
    logic                col_last_s;
    logic [ITER_W-1:0]   iter_inc_s;
    logic                beat_err_s;
    logic                stray_err_s;

    logic                ext_tready_r;
    logic                alpha_sel_r;
    logic                core_clr_r;
    logic                fb_launch_r;
    logic                busy_r;
    logic                done_r;

    assign abort_hit_s = abort && (state_r != ST_IDLE);
    assign beat_last_s = (beat_cnt_r == BEAT_W'(A - 1));
    assign col_last_s  = (col_cnt_r == COL_W'(J - 1));
    assign iter_inc_s  = iter_cnt_r + ITER_W'(1);

    // Malformed beats are still counted; only the error flag records them.
    assign beat_err_s =
        ((state_r == ST_LOAD_EXT) && ext_alpha_tvalid && tlast_mismatch(ext_alpha_tlast, beat_last_s)) ||
        ((state_r == ST_REPLAY)   && fb_alpha_tvalid  && tlast_mismatch(fb_alpha_tlast,  beat_last_s));

    // Column or feedback activity in the wrong state is dropped but flagged.
    assign stray_err_s = (col_done && (state_r != ST_RUN)) ||
                         (fb_alpha_tvalid && (state_r != ST_REPLAY));

    // Next-state and counter update logic; abort overrides every other event.
    always_comb begin
        state_s    = state_r;
        beat_cnt_s = beat_cnt_r;
        col_cnt_s  = col_cnt_r;
        iter_cnt_s = iter_cnt_r;
        max_s      = max_r;
        err_hold_s = err_r;
        if (abort_hit_s) begin
            state_s    = ST_IDLE;
            beat_cnt_s = '0;
            col_cnt_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s    = ST_LOAD_EXT;
                        max_s      = (max_iter == '0) ? ITER_W'(1) : max_iter;
                        iter_cnt_s = '0;
                        beat_cnt_s = '0;
                        col_cnt_s  = '0;
                        err_hold_s = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD_EXT: begin
                    if (ext_alpha_tvalid) begin
                        if (beat_last_s) begin
                            beat_cnt_s = '0;
                            state_s    = ST_RUN;
                        end else begin
                            beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                        end
                    end else begin
                        beat_cnt_s = beat_cnt_r;
                    end
                end
                ST_RUN: begin
                    if (col_done) begin
                        if (col_last_s) begin
                            col_cnt_s  = '0;
                            iter_cnt_s = iter_inc_s;
                            state_s    = (iter_inc_s == max_r) ? ST_DONE : ST_CLEAR;
                        end else begin
                            col_cnt_s = col_cnt_r + COL_W'(1);
                        end
                    end else begin
                        col_cnt_s = col_cnt_r;
                    end
                end
                ST_CLEAR: begin
                    state_s = ST_REPLAY;
                end
                ST_REPLAY: begin
                    if (fb_alpha_tvalid) begin
                        if (beat_last_s) begin
                            beat_cnt_s = '0;
                            state_s    = ST_RUN;
                        end else begin
                            beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                        end
                    end else begin
                        beat_cnt_s = beat_cnt_r;
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Error flag is sticky; an aborted cycle records nothing new.
    always_comb begin
        err_s = err_r;
        if (abort_hit_s) begin
            err_s = err_r;
        end else begin
            err_s = err_hold_s | beat_err_s | stray_err_s;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= '0;
            col_cnt_r  <= '0;
            iter_cnt_r <= '0;
            max_r      <= '0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            beat_cnt_r <= beat_cnt_s;
            col_cnt_r  <= col_cnt_s;
            iter_cnt_r <= iter_cnt_s;
            max_r      <= max_s;
            err_r      <= err_s;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_tready_r <= 1'b0;
            alpha_sel_r  <= 1'b0;
            core_clr_r   <= 1'b0;
            fb_launch_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            ext_tready_r <= (state_s == ST_LOAD_EXT);
            alpha_sel_r  <= (state_s == ST_REPLAY);
            core_clr_r   <= (state_s == ST_CLEAR) || abort_hit_s;
            fb_launch_r  <= (state_s == ST_REPLAY) && (state_r == ST_CLEAR);
            busy_r       <= (state_s != ST_IDLE);
            done_r       <= (state_s == ST_DONE);
        end
    end

    assign ext_alpha_tready = ext_tready_r;
    assign alpha_sel        = alpha_sel_r;
    assign core_clr         = core_clr_r;
    assign fb_launch        = fb_launch_r;
    assign iter_cnt         = iter_cnt_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign err              = err_r;

endmodule

// File: tb/tb_iter_sched_fix_case2.sv
// Scoreboard bench for iter_sched_fix_case2 (J=14, A=2, ITER_W=8).
// Directed stimulus pushes the expected pulse events (done / core_clr /
// fb_launch together with iter_cnt, err, busy) into a queue; a monitor pops
// and compares whenever the DUT raises one of those pulses.
module tb_iter_sched_fix_case2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] max_iter = 8'd0;
    logic       abort = 1'b0;
    logic       ext_alpha_tvalid = 1'b0;
    logic       ext_alpha_tlast = 1'b0;
    logic       ext_alpha_tready;
    logic       fb_alpha_tvalid = 1'b0;
    logic       fb_alpha_tlast = 1'b0;
    logic       col_done = 1'b0;
    logic       alpha_sel;
    logic       core_clr;
    logic       fb_launch;
    logic [7:0] iter_cnt;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] K_DONE   = 2'd0;
    localparam logic [1:0] K_CLR    = 2'd1;
    localparam logic [1:0] K_LAUNCH = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] iter;
        logic       err;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_ev;
    ev_t exp_ev;

    iter_sched_fix_case2 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .max_iter(max_iter), .abort(abort),
        .ext_alpha_tvalid(ext_alpha_tvalid), .ext_alpha_tlast(ext_alpha_tlast),
        .ext_alpha_tready(ext_alpha_tready),
        .fb_alpha_tvalid(fb_alpha_tvalid), .fb_alpha_tlast(fb_alpha_tlast),
        .col_done(col_done), .alpha_sel(alpha_sel), .core_clr(core_clr),
        .fb_launch(fb_launch), .iter_cnt(iter_cnt), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Monitor: one event per cycle at most, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if ((int'(done) + int'(core_clr) + int'(fb_launch)) > 1) begin
                checks++;
                errors++;
                $display("FAIL multi_pulse: done=%0b core_clr=%0b fb_launch=%0b, required at most one", done, core_clr, fb_launch);
            end else if (done || core_clr || fb_launch) begin
                act_ev.kind = done ? K_DONE : (core_clr ? K_CLR : K_LAUNCH);
                act_ev.iter = iter_cnt;
                act_ev.err  = err;
                act_ev.busy = busy;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got kind=%0d iter=%0d err=%0b busy=%0b, required none",
                             act_ev.kind, act_ev.iter, act_ev.err, act_ev.busy);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (act_ev !== exp_ev) begin
                        errors++;
                        $display("FAIL event: got kind=%0d iter=%0d err=%0b busy=%0b, required kind=%0d iter=%0d err=%0b busy=%0b",
                                 act_ev.kind, act_ev.iter, act_ev.err, act_ev.busy,
                                 exp_ev.kind, exp_ev.iter, exp_ev.err, exp_ev.busy);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] it, input logic e, input logic b);
        ev_t ev;
        ev.kind = kind;
        ev.iter = it;
        ev.err  = e;
        ev.busy = b;
        exp_q.push_back(ev);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] mi);
        start = 1'b1;
        max_iter = mi;
        cyc();
        start = 1'b0;
    endtask

    task automatic ext_beat(input logic last);
        ext_alpha_tvalid = 1'b1;
        ext_alpha_tlast = last;
        cyc();
        ext_alpha_tvalid = 1'b0;
        ext_alpha_tlast = 1'b0;
    endtask

    task automatic fb_beat(input logic last);
        fb_alpha_tvalid = 1'b1;
        fb_alpha_tlast = last;
        cyc();
        fb_alpha_tvalid = 1'b0;
        fb_alpha_tlast = 1'b0;
    endtask

    task automatic cols(input int n);
        for (int i = 0; i < n; i++) begin
            col_done = 1'b1;
            cyc();
        end
        col_done = 1'b0;
    endtask

    // After the 14th col_done of a non-final iteration: CLEAR cycle, then REPLAY.
    task automatic replay_clean();
        cyc();
        fb_beat(1'b0);
        fb_beat(1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   32'(busy), 32'd0);
        chk({tag, "_done"},   32'(done), 32'd0);
        chk({tag, "_clr"},    32'(core_clr), 32'd0);
        chk({tag, "_launch"}, 32'(fb_launch), 32'd0);
        chk({tag, "_sel"},    32'(alpha_sel), 32'd0);
        chk({tag, "_tready"}, 32'(ext_alpha_tready), 32'd0);
        chk({tag, "_iter"},   32'(iter_cnt), 32'd0);
        chk({tag, "_err"},    32'(err), 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single iteration, clean beats
        expect_ev(K_DONE, 8'd1, 1'b0, 1'b1);
        do_start(8'd1);
        chk("load_tready", 32'(ext_alpha_tready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        ext_beat(1'b0);
        ext_beat(1'b1);
        chk("run_tready", 32'(ext_alpha_tready), 32'd0);
        cols(14);
        cyc();
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_iter_hold", 32'(iter_cnt), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Three iterations: two CLEAR/REPLAY rounds
        expect_ev(K_CLR, 8'd1, 1'b0, 1'b1);
        expect_ev(K_LAUNCH, 8'd1, 1'b0, 1'b1);
        expect_ev(K_CLR, 8'd2, 1'b0, 1'b1);
        expect_ev(K_LAUNCH, 8'd2, 1'b0, 1'b1);
        expect_ev(K_DONE, 8'd3, 1'b0, 1'b1);
        do_start(8'd3);
        ext_beat(1'b0);
        ext_beat(1'b1);
        cols(14);
        cyc();
        chk("replay_sel", 32'(alpha_sel), 32'd1);
        fb_beat(1'b0);
        fb_beat(1'b1);
        chk("run_sel", 32'(alpha_sel), 32'd0);
        cols(14);
        replay_clean();
        cols(14);
        cyc();

        // tlast on beat 0: error, but the run still completes
        expect_ev(K_DONE, 8'd1, 1'b1, 1'b1);
        do_start(8'd1);
        ext_beat(1'b1);
        chk("bad_tlast_err", 32'(err), 32'd1);
        chk("bad_tlast_still_load", 32'(ext_alpha_tready), 32'd1);
        ext_beat(1'b1);
        chk("bad_tlast_run", 32'(ext_alpha_tready), 32'd0);
        cols(14);
        cyc();

        // Abort on the 5th col_done of iteration 2
        expect_ev(K_CLR, 8'd1, 1'b0, 1'b1);
        expect_ev(K_LAUNCH, 8'd1, 1'b0, 1'b1);
        expect_ev(K_CLR, 8'd1, 1'b0, 1'b0);
        do_start(8'd3);
        chk("start_clears_err", 32'(err), 32'd0);
        ext_beat(1'b0);
        ext_beat(1'b1);
        cols(14);
        replay_clean();
        cols(4);
        col_done = 1'b1;
        abort = 1'b1;
        cyc();
        col_done = 1'b0;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_clr", 32'(core_clr), 32'd1);
        chk("abort_err", 32'(err), 32'd0);
        cyc();
        chk("abort_clr_once", 32'(core_clr), 32'd0);

        // col_done in IDLE, max_iter=0, start during RUN ignored
        cols(1);
        chk("idle_col_err", 32'(err), 32'd1);
        chk("idle_col_busy", 32'(busy), 32'd0);
        expect_ev(K_DONE, 8'd1, 1'b0, 1'b1);
        do_start(8'd0);
        chk("start0_err_clr", 32'(err), 32'd0);
        ext_beat(1'b0);
        ext_beat(1'b1);
        do_start(8'd5);
        chk("run_start_ignored", 32'(ext_alpha_tready), 32'd0);
        cols(14);
        cyc();
        chk("max0_iter", 32'(iter_cnt), 32'd1);
        fb_beat(1'b0);
        chk("idle_fb_err", 32'(err), 32'd1);

        // Reset during REPLAY, then a fresh clean run
        expect_ev(K_CLR, 8'd1, 1'b0, 1'b1);
        expect_ev(K_LAUNCH, 8'd1, 1'b0, 1'b1);
        expect_ev(K_DONE, 8'd1, 1'b0, 1'b1);
        do_start(8'd2);
        ext_beat(1'b0);
        ext_beat(1'b1);
        cols(14);
        cyc();
        fb_beat(1'b1);
        chk("replay_bad_tlast_err", 32'(err), 32'd1);
        chk("replay_sel_hold", 32'(alpha_sel), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_start(8'd1);
        ext_beat(1'b0);
        ext_beat(1'b1);
        cols(14);
        cyc();
        chk("post_rst_iter", 32'(iter_cnt), 32'd1);

        repeat (3) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
